// File: rtl/interboard_tx_arbiter_if.sv
// Request/transmit bundle between the requesters, the link transmitter and the arbiter.
interface interboard_tx_arbiter_if;
    logic [2:0]  req;
    logic [65:0] req_payload;
    logic        tx_done;
    logic        err_clr;
    logic        tx_start;
    logic [21:0] tx_payload;
    logic [2:0]  grant;
    logic [2:0]  req_done;
    logic        busy;
    logic        link_err;

    modport slave (
        input  req, req_payload, tx_done, err_clr,
        output tx_start, tx_payload, grant, req_done, busy, link_err
    );

    modport master (
        output req, req_payload, tx_done, err_clr,
        input  tx_start, tx_payload, grant, req_done, busy, link_err
    );
endinterface

// File: rtl/interboard_tx_arbiter.sv
// Arbitrates three message sources onto one inter-board link, with timeout,
// backoff and bounded retry; a sticky link_err records an abandoned message.
module interboard_tx_arbiter #(
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int MAX_RETRY      = 3,
    parameter int BACKOFF_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    interboard_tx_arbiter_if.slave bus
);
    localparam int MSG_W = 22;
    localparam int TMO_W = ($clog2(TIMEOUT_CYCLES) > 20) ? $clog2(TIMEOUT_CYCLES) : 20;
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int BO_W  = (BACKOFF_CYCLES > 1) ? $clog2(BACKOFF_CYCLES) : 1;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
    localparam logic [BO_W-1:0]  BO_LAST  = BO_W'((BACKOFF_CYCLES > 0) ? BACKOFF_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, START, WAIT_DONE, BACKOFF} state_t;

    state_t             state;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [RTY_W-1:0]   retry_cnt;
    logic [BO_W-1:0]    bo_cnt;
    logic               rr_pref2;
    logic               tx_start_r;
    logic [MSG_W-1:0]   tx_payload_r;
    logic [2:0]         grant_r;
    logic [2:0]         req_done_r;
    logic               busy_r;
    logic               link_err_r;
    logic [2:0]         win;
    logic [MSG_W-1:0]   win_payload;

    // req[0] is absolute priority; rr_pref2 breaks a 1-vs-2 tie toward the one not served last.
    always_comb begin
        win = 3'b000;
        if (bus.req[0])
            win = 3'b001;
        else if (bus.req[1] && bus.req[2])
            win = rr_pref2 ? 3'b100 : 3'b010;
        else if (bus.req[1])
            win = 3'b010;
        else if (bus.req[2])
            win = 3'b100;
    end

    always_comb begin
        win_payload = bus.req_payload[MSG_W-1:0];
        if (win[1])
            win_payload = bus.req_payload[2*MSG_W-1:MSG_W];
        else if (win[2])
            win_payload = bus.req_payload[3*MSG_W-1:2*MSG_W];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            tmo_cnt      <= '0;
            retry_cnt    <= '0;
            bo_cnt       <= '0;
            rr_pref2     <= 1'b0;
            tx_start_r   <= 1'b0;
            tx_payload_r <= '0;
            grant_r      <= 3'b000;
            req_done_r   <= 3'b000;
            busy_r       <= 1'b0;
            link_err_r   <= 1'b0;
        end else begin
            tx_start_r <= 1'b0;
            req_done_r <= 3'b000;
            if (bus.err_clr)
                link_err_r <= 1'b0;

            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        grant_r      <= win;
                        tx_payload_r <= win_payload;
                        tx_start_r   <= 1'b1;
                        tmo_cnt      <= '0;
                        busy_r       <= 1'b1;
                        state        <= START;
                    end
                end

                // The timeout window opens with the tx_start cycle itself,
                // so START already counts as its first cycle.
                START: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    state   <= WAIT_DONE;
                end

                WAIT_DONE: begin
                    if (bus.tx_done) begin
                        req_done_r <= grant_r;
                        grant_r    <= 3'b000;
                        retry_cnt  <= '0;
                        busy_r     <= 1'b0;
                        state      <= IDLE;
                        if (grant_r[1])
                            rr_pref2 <= 1'b1;
                        else if (grant_r[2])
                            rr_pref2 <= 1'b0;
                    end else if (tmo_cnt >= TMO_LAST) begin
                        if (retry_cnt < RTY_MAX) begin
                            bo_cnt <= '0;
                            state  <= BACKOFF;
                        end else begin
                            // Abandon the message; this set overrides a same-cycle err_clr.
                            link_err_r <= 1'b1;
                            grant_r    <= 3'b000;
                            retry_cnt  <= '0;
                            busy_r     <= 1'b0;
                            state      <= IDLE;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                BACKOFF: begin
                    if (bo_cnt >= BO_LAST) begin
                        retry_cnt  <= retry_cnt + 1'b1;
                        tx_start_r <= 1'b1;
                        tmo_cnt    <= '0;
                        state      <= START;
                    end else begin
                        bo_cnt <= bo_cnt + 1'b1;
                    end
                end

                default: begin
                    grant_r <= 3'b000;
                    busy_r  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.tx_start   = tx_start_r;
    assign bus.tx_payload = tx_payload_r;
    assign bus.grant      = grant_r;
    assign bus.req_done   = req_done_r;
    assign bus.busy       = busy_r;
    assign bus.link_err   = link_err_r;
endmodule
